countdown_controller: RTL and testbench



---
 rtl/countdown_controller.sv | 182 ++++++++++++++++++
 tb/tb_countdown_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_controller.sv
// countdown_controller
//   Sequencing FSM for the N-bit countdown shown on the two 7-segment
//   displays. A prescaler produces the count-step tick. Start and pause
//   buttons are edge-detected. A preset can be loaded while idle or paused.
//   Completion is flagged with done and a blinking blank request.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   start_btn  start / resume / acknowledge (rising edge used)
//   pause_btn  pause / abort (rising edge used)
//   load_en    load load_val into count (IDLE and PAUSE only)
//   load_val   preset value
//   count      current count, to the display converters (registered)
//   tick       one-cycle pulse per count step (registered)
//   state      00 IDLE, 01 RUN, 10 PAUSE, 11 DONE (registered)
//   done       high while in DONE (registered)
//   blank      display blank request, toggles per tick in DONE (registered)
//
// Build option
//   COUNTDOWN_AUTO_RELOAD_EN: the counter never stops. Reaching zero pulses
//   done for one cycle, and the next tick wraps the count to 2^N-1. DONE is
//   never entered.
//
// state | meaning
// IDLE  | waiting for start; preset load allowed; prescaler cleared
// RUN   | prescaler running, count decrements on every tick
// PAUSE | count and prescaler frozen; start resumes, pause aborts
// DONE  | count held at 0, blank toggles per tick; start acknowledges

module countdown_controller #(
  parameter int N        = 6,
  parameter int PRESCALE = 50_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_btn,
  input  logic         pause_btn,
  input  logic         load_en,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         tick,
  output logic [1:0]   state,
  output logic         done,
  output logic         blank
);

  localparam int             PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [N-1:0]   CNT_MAX    = '1;
  localparam logic [N-1:0]   CNT_ONE    = N'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   count_q, count_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           tick_q, tick_d;
  logic           done_q, done_d;
  logic           blank_q, blank_d;
  logic           start_q, pause_q;
  logic           start_rise, pause_rise, step;
  logic [N-1:0]   idle_cnt;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic           done_pulse;
`endif

  always_comb begin
    start_rise = start_btn & ~start_q;
    pause_rise = pause_btn & ~pause_q;
    step       = ((state_q == S_RUN) || (state_q == S_DONE)) && (presc_q == PRESC_LAST);
    // In IDLE a start that coincides with a load is judged on the loaded value.
    idle_cnt   = load_en ? load_val : count_q;

    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    blank_d = blank_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    done_pulse = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        count_d = idle_cnt;
        if (start_rise) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          state_d = S_RUN;
`else
          state_d = (idle_cnt != '0) ? S_RUN : S_DONE;
`endif
        end
      end

      S_RUN: begin
        presc_d = step ? '0 : presc_q + PW'(1);
        tick_d  = step;
        if (step) count_d = count_q - CNT_ONE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        done_pulse = step && (count_q == CNT_ONE);
        if (pause_rise) state_d = S_PAUSE;
`else
        // Reaching zero takes precedence over a coincident pause. A zero
        // preset resumed from PAUSE also stops here instead of wrapping.
        if (step && (count_q <= CNT_ONE)) begin
          count_d = '0;
          state_d = S_DONE;
        end else if (pause_rise) begin
          state_d = S_PAUSE;
        end
`endif
      end

      S_PAUSE: begin
        if (load_en) count_d = load_val;
        if (start_rise) begin
          state_d = S_RUN;
        end else if (pause_rise) begin
          state_d = S_IDLE;
          count_d = CNT_MAX;
        end
      end

      S_DONE: begin
        presc_d = step ? '0 : presc_q + PW'(1);
        tick_d  = step;
        count_d = '0;
        if (step) blank_d = ~blank_q;
        if (start_rise) begin
          state_d = S_IDLE;
          count_d = CNT_MAX;
          blank_d = 1'b0;
          presc_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    done_d = done_pulse;
`else
    done_d = (state_d == S_DONE);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= CNT_MAX;
      presc_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      blank_q <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      blank_q <= blank_d;
      start_q <= start_btn;
      pause_q <= pause_btn;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign state = state_q;
  assign done  = done_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_countdown_controller.sv
module tb_countdown_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn, pause_btn, load_en;
  logic [5:0] load_val;
  logic [5:0] count;
  logic       tick, done, blank;
  logic [1:0] state;

  localparam logic [1:0] ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10, ST_DONE = 2'b11;

  countdown_controller #(.N(6), .PRESCALE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_btn (start_btn),
    .pause_btn (pause_btn),
    .load_en   (load_en),
    .load_val  (load_val),
    .count     (count),
    .tick      (tick),
    .state     (state),
    .done      (done),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  // Expected tick: clock edge it appears on and the outputs that go with it.
  typedef struct {
    int         cyc;
    logic [5:0] cnt;
    logic [1:0] st;
    logic       dn;
    logic       bl;
  } exp_t;
  exp_t sb[$];

  // Tick monitor: every tick must match the next scoreboard entry.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (reset === 1'b0 && tick === 1'b1) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_tick: cyc=%0d count=%0d state=%0d, required no tick", cyc, count, state);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc || count !== e.cnt || state !== e.st || done !== e.dn || blank !== e.bl)
          $display("FAIL tick_scoreboard: got cyc=%0d count=%0d state=%0d done=%0b blank=%0b, required cyc=%0d count=%0d state=%0d done=%0b blank=%0b",
                   cyc, count, state, done, blank, e.cyc, e.cnt, e.st, e.dn, e.bl);
        else
          n_pass++;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tick(input int c, input int cnt, input logic [1:0] st, input logic dn, input logic bl);
    exp_t e;
    e.cyc = c; e.cnt = 6'(cnt); e.st = st; e.dn = dn; e.bl = bl;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    reset = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; load_en = 1'b0; load_val = '0;
    wait_cycles(2);
    n_total++;
    if (count !== 6'd63 || state !== ST_IDLE) $display("FAIL reset_count_state: count=%0d state=%0d, required 63/0", count, state);
    else n_pass++;
    n_total++;
    if ({done, tick, blank} !== 3'b000) $display("FAIL reset_flags: done/tick/blank=%b, required 000", {done, tick, blank});
    else n_pass++;
    reset = 1'b0;
    wait_cycles(1);
  endtask

  int t_done;

  task automatic test_run_to_done;
    int c;
    load_en = 1'b1; load_val = 6'd5;
    wait_cycles(1);
    n_total++;
    if (count !== 6'd5 || state !== ST_IDLE) $display("FAIL idle_load: count=%0d state=%0d, required 5/0", count, state);
    else n_pass++;
    load_en = 1'b0; start_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_RUN) $display("FAIL start_to_run: state=%0d, required 1", state);
    else n_pass++;
    c = cyc;
    for (int k = 1; k <= 5; k++)
      push_tick(c + 4*k, 5 - k, (k == 5) ? ST_DONE : ST_RUN, (k == 5), 1'b0);
    start_btn = 1'b0;
    wait_cycles(2);
    // Start rise and load are both ignored while running.
    start_btn = 1'b1; load_en = 1'b1; load_val = 6'd20;
    wait_cycles(3);
    start_btn = 1'b0; load_en = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) wait_cycles(1);
    n_total++;
    if (sb.size() != 0) $display("FAIL run_ticks_drained: pending=%0d, required 0", sb.size());
    else n_pass++;
    n_total++;
    if (state !== ST_DONE || done !== 1'b1 || count !== 6'd0)
      $display("FAIL done_reached: state=%0d done=%0b count=%0d, required 3/1/0", state, done, count);
    else n_pass++;
    t_done = c + 20;
  endtask

  task automatic test_done_blink;
    pause_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_DONE) $display("FAIL done_ignores_pause: state=%0d, required 3", state);
    else n_pass++;
    pause_btn = 1'b0;
    push_tick(t_done + 4,  0, ST_DONE, 1'b1, 1'b1);
    push_tick(t_done + 8,  0, ST_DONE, 1'b1, 1'b0);
    push_tick(t_done + 12, 0, ST_DONE, 1'b1, 1'b1);
    for (int i = 0; i < 30 && sb.size() != 0; i++) wait_cycles(1);
    n_total++;
    if (sb.size() != 0) $display("FAIL blink_ticks_drained: pending=%0d, required 0", sb.size());
    else n_pass++;
    start_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_IDLE || count !== 6'd63 || done !== 1'b0 || blank !== 1'b0)
      $display("FAIL done_ack: state=%0d count=%0d done=%0b blank=%0b, required 0/63/0/0", state, count, done, blank);
    else n_pass++;
    start_btn = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_zero_start;
    load_en = 1'b1; load_val = 6'd0; start_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_DONE || done !== 1'b1 || count !== 6'd0)
      $display("FAIL zero_start_done: state=%0d done=%0b count=%0d, required 3/1/0", state, done, count);
    else n_pass++;
    load_en = 1'b0; start_btn = 1'b0;
    wait_cycles(1);
    start_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_IDLE || count !== 6'd63) $display("FAIL zero_start_ack: state=%0d count=%0d, required 0/63", state, count);
    else n_pass++;
    start_btn = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_pause_resume;
    int c, r, bad;
    load_en = 1'b1; load_val = 6'd5; start_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_RUN || count !== 6'd5) $display("FAIL load_and_start: state=%0d count=%0d, required 1/5", state, count);
    else n_pass++;
    c = cyc;
    load_en = 1'b0; start_btn = 1'b0;
    push_tick(c + 4, 4, ST_RUN, 1'b0, 1'b0);
    push_tick(c + 8, 3, ST_RUN, 1'b0, 1'b0);
    wait_cycles(9);
    pause_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_PAUSE || count !== 6'd3 || sb.size() != 0)
      $display("FAIL pause_entry: state=%0d count=%0d pending=%0d, required 2/3/0", state, count, sb.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 1) pause_btn = 1'b0;
      wait_cycles(1);
      if (tick !== 1'b0 || count !== 6'd3 || state !== ST_PAUSE) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL pause_frozen: bad_cycles=%0d, required 0", bad);
    else n_pass++;
    start_btn = 1'b1;
    wait_cycles(1);
    r = cyc;
    start_btn = 1'b0;
    // Paused with the prescaler at 2: two more edges reach the tick.
    push_tick(r + 2, 2, ST_RUN, 1'b0, 1'b0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) wait_cycles(1);
    n_total++;
    if (sb.size() != 0 || state !== ST_RUN)
      $display("FAIL resume_tick: pending=%0d state=%0d, required 0/1", sb.size(), state);
    else n_pass++;
  endtask

  task automatic test_pause_abort;
    pause_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_PAUSE || count !== 6'd2) $display("FAIL pause_again: state=%0d count=%0d, required 2/2", state, count);
    else n_pass++;
    pause_btn = 1'b0;
    wait_cycles(1);
    start_btn = 1'b1; pause_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_RUN) $display("FAIL start_wins: state=%0d, required 1", state);
    else n_pass++;
    start_btn = 1'b0; pause_btn = 1'b0;
    wait_cycles(1);
    pause_btn = 1'b1;
    wait_cycles(1);
    pause_btn = 1'b0; load_en = 1'b1; load_val = 6'd17;
    wait_cycles(1);
    n_total++;
    if (state !== ST_PAUSE || count !== 6'd17) $display("FAIL pause_load: state=%0d count=%0d, required 2/17", state, count);
    else n_pass++;
    load_en = 1'b0; pause_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_IDLE || count !== 6'd63) $display("FAIL abort: state=%0d count=%0d, required 0/63", state, count);
    else n_pass++;
    pause_btn = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_reset_mid_run;
    start_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_RUN || count !== 6'd63) $display("FAIL run_from_63: state=%0d count=%0d, required 1/63", state, count);
    else n_pass++;
    start_btn = 1'b0;
    wait_cycles(3);
    // Reset lands on the edge that would have produced the first tick.
    reset = 1'b1;
    wait_cycles(1);
    n_total++;
    if (tick !== 1'b0 || count !== 6'd63 || state !== ST_IDLE || done !== 1'b0)
      $display("FAIL reset_mid_run: tick=%0b count=%0d state=%0d done=%0b, required 0/63/0/0", tick, count, state, done);
    else n_pass++;
    reset = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_auto_reload;
    int c, bad, dcnt;
    load_en = 1'b1; load_val = 6'd2; start_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_RUN || count !== 6'd2) $display("FAIL auto_start: state=%0d count=%0d, required 1/2", state, count);
    else n_pass++;
    c = cyc;
    load_en = 1'b0; start_btn = 1'b0;
    push_tick(c + 4,  1,  ST_RUN, 1'b0, 1'b0);
    push_tick(c + 8,  0,  ST_RUN, 1'b1, 1'b0);
    push_tick(c + 12, 63, ST_RUN, 1'b0, 1'b0);
    push_tick(c + 16, 62, ST_RUN, 1'b0, 1'b0);
    bad = 0; dcnt = 0;
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      wait_cycles(1);
      if (state !== ST_RUN || blank !== 1'b0) bad++;
      if (done === 1'b1) dcnt++;
    end
    n_total++;
    if (sb.size() != 0 || bad != 0) $display("FAIL auto_wrap: pending=%0d bad_cycles=%0d, required 0/0", sb.size(), bad);
    else n_pass++;
    n_total++;
    if (dcnt != 1) $display("FAIL auto_done_pulse: done_cycles=%0d, required 1", dcnt);
    else n_pass++;
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    load_en = 1'b1; load_val = 6'd0; start_btn = 1'b1;
    wait_cycles(1);
    n_total++;
    if (state !== ST_RUN || count !== 6'd0 || done !== 1'b0)
      $display("FAIL auto_zero_start: state=%0d count=%0d done=%0b, required 1/0/0", state, count, done);
    else n_pass++;
    load_en = 1'b0; start_btn = 1'b0; reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    test_run_to_done();
    test_done_blink();
    test_zero_start();
`endif
    test_pause_resume();
    test_pause_abort();
    test_reset_mid_run();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
